// File: rtl/instr_mem_bank_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : instr_mem_arb_pkg
// Brief    : Shared types and round-robin pick helper for the bank arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package instr_mem_arb_pkg;

    typedef enum logic [0:0] {
        ARB_RR    = 1'b0,
        ARB_FIXED = 1'b1
    } arb_mode_e;

    localparam int c_MAX_CPUS = 16;
    localparam int c_IDX_W    = 4;

    typedef logic [c_MAX_CPUS-1:0] req_vec_t;
    typedef logic [c_IDX_W-1:0]    idx_t;

    // Requests are zero-padded to c_MAX_CPUS, so scanning the full padded
    // width from ptr+1 with natural 4-bit wrap is equivalent to mod N.
    function automatic idx_t rr_pick(input req_vec_t req, input idx_t ptr);
        idx_t w_pick;
        idx_t w_j;
        logic w_found;
        w_pick  = '0;
        w_found = 1'b0;
        for (int i = 1; i <= c_MAX_CPUS; i++) begin
            w_j = ptr + idx_t'(i);
            if (!w_found && req[w_j]) begin
                w_pick  = w_j;
                w_found = 1'b1;
            end
        end
        return w_pick;
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_mem_bank_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_mem_bank_arbiter_if
// Brief    : CPU fetch ports and bank SRAM ports of the bank arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface instr_mem_bank_arbiter_if #(
    parameter int N_CPUS     = 3,
    parameter int N_BANKS    = 3,
    parameter int BANK_DEPTH = 32,
    parameter int DATA_W     = 32
);
    localparam int OFF_W  = $clog2(BANK_DEPTH);
    localparam int ADDR_W = $clog2(BANK_DEPTH * N_BANKS);

    logic [N_CPUS-1:0]         cpu_req;
    logic [N_CPUS*ADDR_W-1:0]  cpu_addr;
    logic [N_CPUS-1:0]         cpu_gnt;
    logic [N_CPUS-1:0]         cpu_rsp_vld;
    logic [N_CPUS-1:0]         cpu_rsp_err;
    logic [N_CPUS*DATA_W-1:0]  cpu_rsp_data;
    logic [N_BANKS-1:0]        bank_re;
    logic [N_BANKS*OFF_W-1:0]  bank_ra;
    logic [N_BANKS*DATA_W-1:0] bank_rd;

    modport slave (
        input  cpu_req, cpu_addr, bank_rd,
        output cpu_gnt, cpu_rsp_vld, cpu_rsp_err, cpu_rsp_data, bank_re, bank_ra
    );

    modport master (
        output cpu_req, cpu_addr, bank_rd,
        input  cpu_gnt, cpu_rsp_vld, cpu_rsp_err, cpu_rsp_data, bank_re, bank_ra
    );

endinterface
`default_nettype wire

// File: rtl/instr_mem_bank_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Per-bank one-hot arbiter, round-robin or fixed lowest-index.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import instr_mem_arb_pkg::*;
#(
    parameter int        N    = 3,
    parameter arb_mode_e MODE = ARB_RR,
    localparam int       IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic [N-1:0]     req,
    output logic      [N-1:0]     gnt,
    output logic      [IDX_W-1:0] gnt_idx
);

    req_vec_t w_req_pad;
    idx_t     w_ptr;
    idx_t     w_pick;

    always_comb begin
        w_req_pad        = '0;
        w_req_pad[N-1:0] = req;
    end

    generate
        if (MODE == ARB_RR) begin : g_rr
            idx_t r_ptr;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ptr <= idx_t'(N - 1);
                end else if (|req) begin
                    r_ptr <= w_pick;
                end
            end
            assign w_ptr = r_ptr;
        end else begin : g_fixed
            // Starting just past the top index makes the scan begin at CPU0.
            assign w_ptr = idx_t'(c_MAX_CPUS - 1);
        end
    endgenerate

    assign w_pick = rr_pick(w_req_pad, w_ptr);

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        for (int c = 0; c < N; c++) begin
            if (|req && (w_pick == idx_t'(c))) begin
                gnt[c]  = 1'b1;
                gnt_idx = IDX_W'(c);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/instr_mem_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : instr_mem_bank_arbiter
// Brief    : Shares N_BANKS instruction SRAM banks among N_CPUS fetch ports
//            with a fixed 2-cycle response pipeline. Requires N_BANKS >= 2.
// Revision : 1.0 - initial release
// ============================================================================
module instr_mem_bank_arbiter
    import instr_mem_arb_pkg::*;
#(
    parameter int N_CPUS     = 3,
    parameter int N_BANKS    = 3,
    parameter int BANK_DEPTH = 32,
    parameter int DATA_W     = 32,
    parameter int ARB_MODE   = 0
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    instr_mem_bank_arbiter_if.slave bus
);

    localparam int        OFF_W  = $clog2(BANK_DEPTH);
    localparam int        ADDR_W = $clog2(BANK_DEPTH * N_BANKS);
    localparam int        BANK_W = ADDR_W - OFF_W;
    localparam int        IDX_W  = (N_CPUS > 1) ? $clog2(N_CPUS) : 1;
    localparam arb_mode_e c_MODE = (ARB_MODE == 1) ? ARB_FIXED : ARB_RR;

    logic [BANK_W-1:0] w_bank [N_CPUS];
    logic [OFF_W-1:0]  w_off  [N_CPUS];
    logic [N_CPUS-1:0] w_req;
    logic [N_CPUS-1:0] w_oor;
    logic [N_CPUS-1:0] w_cpu_gnt;

    logic [N_CPUS-1:0] w_bank_req [N_BANKS];
    logic [N_CPUS-1:0] w_bank_gnt [N_BANKS];
    logic [IDX_W-1:0]  w_gnt_idx  [N_BANKS];

    logic [N_CPUS-1:0]        r_s1_vld;
    logic [N_CPUS-1:0]        r_s1_err;
    logic [BANK_W-1:0]        r_s1_bank [N_CPUS];
    logic [N_CPUS-1:0]        r_s2_vld;
    logic [N_CPUS-1:0]        r_s2_err;
    logic [N_CPUS*DATA_W-1:0] r_s2_data;
    logic [N_CPUS*DATA_W-1:0] w_route;

    // Gating requests with rst_n keeps grants and bank enables low in reset.
    assign w_req = bus.cpu_req & {N_CPUS{rst_n}};

    generate
        for (genvar c = 0; c < N_CPUS; c++) begin : g_dec
            assign w_bank[c] = bus.cpu_addr[c*ADDR_W+OFF_W +: BANK_W];
            assign w_off[c]  = bus.cpu_addr[c*ADDR_W +: OFF_W];
            assign w_oor[c]  = (32'(w_bank[c]) >= 32'(N_BANKS));
        end

        for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
            logic w_re;

            always_comb begin
                w_bank_req[b] = '0;
                for (int c = 0; c < N_CPUS; c++) begin
                    w_bank_req[b][c] = w_req[c] & ~w_oor[c] & (w_bank[c] == BANK_W'(b));
                end
            end

            rr_arbiter #(
                .N    (N_CPUS),
                .MODE (c_MODE)
            ) u_arb (
                .clk     (clk),
                .rst_n   (rst_n),
                .req     (w_bank_req[b]),
                .gnt     (w_bank_gnt[b]),
                .gnt_idx (w_gnt_idx[b])
            );

            assign w_re          = |w_bank_req[b];
            assign bus.bank_re[b] = w_re;

            always_comb begin
                bus.bank_ra[b*OFF_W +: OFF_W] = '0;
                for (int c = 0; c < N_CPUS; c++) begin
                    if (w_re && (w_gnt_idx[b] == IDX_W'(c))) begin
                        bus.bank_ra[b*OFF_W +: OFF_W] = w_off[c];
                    end
                end
            end
        end
    endgenerate

    // Out-of-range requests are accepted immediately with no bank access.
    always_comb begin
        w_cpu_gnt = '0;
        for (int c = 0; c < N_CPUS; c++) begin
            w_cpu_gnt[c] = w_req[c] & w_oor[c];
            for (int b = 0; b < N_BANKS; b++) begin
                w_cpu_gnt[c] = w_cpu_gnt[c] | w_bank_gnt[b][c];
            end
        end
    end

    assign bus.cpu_gnt = w_cpu_gnt;

    always_comb begin
        w_route = '0;
        for (int c = 0; c < N_CPUS; c++) begin
            for (int b = 0; b < N_BANKS; b++) begin
                if (r_s1_vld[c] && !r_s1_err[c] && (r_s1_bank[c] == BANK_W'(b))) begin
                    w_route[c*DATA_W +: DATA_W] = bus.bank_rd[b*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld  <= '0;
            r_s1_err  <= '0;
            r_s2_vld  <= '0;
            r_s2_err  <= '0;
            r_s2_data <= '0;
            for (int c = 0; c < N_CPUS; c++) begin
                r_s1_bank[c] <= '0;
            end
        end else begin
            r_s1_vld  <= w_cpu_gnt;
            r_s1_err  <= w_cpu_gnt & w_oor;
            r_s1_bank <= w_bank;
            r_s2_vld  <= r_s1_vld;
            r_s2_err  <= r_s1_vld & r_s1_err;
            r_s2_data <= w_route;
        end
    end

    assign bus.cpu_rsp_vld  = r_s2_vld;
    assign bus.cpu_rsp_err  = r_s2_err;
    assign bus.cpu_rsp_data = r_s2_data;

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_mem_bank_arbiter
// Brief    : Directed bench for the instruction-memory bank arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_mem_bank_arbiter;

    localparam int NC = 3;
    localparam int NB = 3;
    localparam int BD = 32;
    localparam int DW = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    instr_mem_bank_arbiter_if #(.N_CPUS(NC), .N_BANKS(NB), .BANK_DEPTH(BD), .DATA_W(DW)) bus_rr ();
    instr_mem_bank_arbiter_if #(.N_CPUS(NC), .N_BANKS(NB), .BANK_DEPTH(BD), .DATA_W(DW)) bus_fx ();

    instr_mem_bank_arbiter #(.N_CPUS(NC), .N_BANKS(NB), .BANK_DEPTH(BD), .DATA_W(DW), .ARB_MODE(0))
        u_dut_rr (.clk(clk), .rst_n(rst_n), .bus(bus_rr.slave));

    instr_mem_bank_arbiter #(.N_CPUS(NC), .N_BANKS(NB), .BANK_DEPTH(BD), .DATA_W(DW), .ARB_MODE(1))
        u_dut_fx (.clk(clk), .rst_n(rst_n), .bus(bus_fx.slave));

    function automatic logic [31:0] word(input int b, input int o);
        return 32'hA000_0000 | 32'(b << 8) | 32'(o);
    endfunction

    // Bank SRAM models: one-cycle read latency.
    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (bus_rr.bank_re[b]) bus_rr.bank_rd[b*32 +: 32] <= word(b, int'(bus_rr.bank_ra[b*5 +: 5]));
            if (bus_fx.bank_re[b]) bus_fx.bank_rd[b*32 +: 32] <= word(b, int'(bus_fx.bank_ra[b*5 +: 5]));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [2:0] req, input logic [6:0] a0, input logic [6:0] a1, input logic [6:0] a2);
        bus_rr.cpu_req  = req;
        bus_rr.cpu_addr = {a2, a1, a0};
    endtask

    task automatic test_reset();
        set_req(3'b111, 7'h00, 7'h01, 7'h02);
        cyc(); cyc(); #1;
        checks++; if (bus_rr.cpu_gnt !== 3'b000) $display("FAIL reset_gnt got %b want 000", bus_rr.cpu_gnt); else passed++;
        checks++; if (bus_rr.bank_re !== 3'b000) $display("FAIL reset_bank_re got %b want 000", bus_rr.bank_re); else passed++;
        checks++; if (bus_rr.cpu_rsp_vld !== 3'b000) $display("FAIL reset_rsp_vld got %b want 000", bus_rr.cpu_rsp_vld); else passed++;
        checks++; if (bus_rr.cpu_rsp_err !== 3'b000) $display("FAIL reset_rsp_err got %b want 000", bus_rr.cpu_rsp_err); else passed++;
        checks++; if (bus_rr.cpu_rsp_data !== 96'h0) $display("FAIL reset_rsp_data got %h want 0", bus_rr.cpu_rsp_data); else passed++;
        cyc();
        set_req(3'b000, 7'h00, 7'h00, 7'h00);
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_single();
        cyc();
        set_req(3'b001, 7'h25, 7'h00, 7'h00);
        #1;
        checks++; if (bus_rr.cpu_gnt !== 3'b001) $display("FAIL single_gnt got %b want 001", bus_rr.cpu_gnt); else passed++;
        checks++; if (bus_rr.bank_re !== 3'b010) $display("FAIL single_bank_re got %b want 010", bus_rr.bank_re); else passed++;
        checks++; if (bus_rr.bank_ra !== 15'h00A0) $display("FAIL single_bank_ra got %h want 00a0", bus_rr.bank_ra); else passed++;
        cyc();
        set_req(3'b000, 7'h00, 7'h00, 7'h00);
        #1;
        checks++; if (bus_rr.cpu_rsp_vld !== 3'b000) $display("FAIL single_vld_t1 got %b want 000", bus_rr.cpu_rsp_vld); else passed++;
        cyc(); #1;
        checks++; if (bus_rr.cpu_rsp_vld !== 3'b001) $display("FAIL single_vld_t2 got %b want 001", bus_rr.cpu_rsp_vld); else passed++;
        checks++; if (bus_rr.cpu_rsp_err !== 3'b000) $display("FAIL single_err got %b want 000", bus_rr.cpu_rsp_err); else passed++;
        checks++; if (bus_rr.cpu_rsp_data[31:0] !== 32'hA000_0105) $display("FAIL single_data got %h want a0000105", bus_rr.cpu_rsp_data[31:0]); else passed++;
        cyc(); #1;
        checks++; if (bus_rr.cpu_rsp_vld !== 3'b000) $display("FAIL single_vld_t3 got %b want 000", bus_rr.cpu_rsp_vld); else passed++;
    endtask

    task automatic test_rr_conflict();
        logic [2:0] exp_g;
        logic [2:0] exp_v;
        int         idx;
        for (int k = 0; k < 9; k++) begin
            cyc();
            set_req((k < 6) ? 3'b111 : 3'b000, 7'h00, 7'h01, 7'h02);
            #1;
            exp_g = (k < 6) ? (3'b001 << (k % 3)) : 3'b000;
            idx   = (k >= 2) ? ((k - 2) % 3) : 0;
            exp_v = (k >= 2 && k < 8) ? (3'b001 << idx) : 3'b000;
            checks++; if (bus_rr.cpu_gnt !== exp_g) $display("FAIL rr_gnt k=%0d got %b want %b", k, bus_rr.cpu_gnt, exp_g); else passed++;
            checks++; if (bus_rr.cpu_rsp_vld !== exp_v) $display("FAIL rr_vld k=%0d got %b want %b", k, bus_rr.cpu_rsp_vld, exp_v); else passed++;
            if (exp_v != 3'b000) begin
                checks++;
                if (bus_rr.cpu_rsp_data[idx*32 +: 32] !== word(0, idx))
                    $display("FAIL rr_data k=%0d got %h want %h", k, bus_rr.cpu_rsp_data[idx*32 +: 32], word(0, idx));
                else passed++;
            end
        end
    endtask

    task automatic test_parallel_banks();
        cyc();
        set_req(3'b111, 7'h03, 7'h23, 7'h43);
        #1;
        checks++; if (bus_rr.cpu_gnt !== 3'b111) $display("FAIL par_gnt got %b want 111", bus_rr.cpu_gnt); else passed++;
        checks++; if (bus_rr.bank_re !== 3'b111) $display("FAIL par_bank_re got %b want 111", bus_rr.bank_re); else passed++;
        checks++; if (bus_rr.bank_ra !== {5'd3, 5'd3, 5'd3}) $display("FAIL par_bank_ra got %h want %h", bus_rr.bank_ra, {5'd3, 5'd3, 5'd3}); else passed++;
        cyc();
        set_req(3'b000, 7'h00, 7'h00, 7'h00);
        cyc(); #1;
        checks++; if (bus_rr.cpu_rsp_vld !== 3'b111) $display("FAIL par_vld got %b want 111", bus_rr.cpu_rsp_vld); else passed++;
        checks++; if (bus_rr.cpu_rsp_data !== {32'hA000_0203, 32'hA000_0103, 32'hA000_0003})
            $display("FAIL par_data got %h want a0000203a0000103a0000003", bus_rr.cpu_rsp_data); else passed++;
    endtask

    task automatic test_out_of_range();
        cyc();
        set_req(3'b100, 7'h00, 7'h00, 7'h60);
        #1;
        checks++; if (bus_rr.cpu_gnt !== 3'b100) $display("FAIL oor_gnt got %b want 100", bus_rr.cpu_gnt); else passed++;
        checks++; if (bus_rr.bank_re !== 3'b000) $display("FAIL oor_bank_re got %b want 000", bus_rr.bank_re); else passed++;
        checks++; if (bus_rr.bank_ra !== 15'h0) $display("FAIL oor_bank_ra got %h want 0", bus_rr.bank_ra); else passed++;
        cyc();
        set_req(3'b000, 7'h00, 7'h00, 7'h00);
        cyc(); #1;
        checks++; if (bus_rr.cpu_rsp_vld !== 3'b100) $display("FAIL oor_vld got %b want 100", bus_rr.cpu_rsp_vld); else passed++;
        checks++; if (bus_rr.cpu_rsp_err !== 3'b100) $display("FAIL oor_err got %b want 100", bus_rr.cpu_rsp_err); else passed++;
        checks++; if (bus_rr.cpu_rsp_data[95:64] !== 32'h0) $display("FAIL oor_data got %h want 0", bus_rr.cpu_rsp_data[95:64]); else passed++;
    endtask

    task automatic test_fixed_priority();
        for (int k = 0; k < 6; k++) begin
            cyc();
            bus_fx.cpu_req  = (k < 4) ? 3'b101 : 3'b000;
            bus_fx.cpu_addr = {7'h41, 7'h00, 7'h40};
            #1;
            checks++;
            if (bus_fx.cpu_gnt !== ((k < 4) ? 3'b001 : 3'b000))
                $display("FAIL fixed_gnt k=%0d got %b want %b", k, bus_fx.cpu_gnt, (k < 4) ? 3'b001 : 3'b000);
            else passed++;
            if (k >= 2) begin
                checks++;
                if (bus_fx.cpu_rsp_vld !== 3'b001 || bus_fx.cpu_rsp_data[31:0] !== 32'hA000_0200)
                    $display("FAIL fixed_rsp k=%0d got %b/%h want 001/a0000200", k, bus_fx.cpu_rsp_vld, bus_fx.cpu_rsp_data[31:0]);
                else passed++;
            end
        end
        bus_fx.cpu_req = 3'b000;
    endtask

    task automatic test_reset_inflight();
        cyc();
        set_req(3'b010, 7'h00, 7'h01, 7'h00);
        #1;
        checks++; if (bus_rr.cpu_gnt !== 3'b010) $display("FAIL rst_pre_gnt got %b want 010", bus_rr.cpu_gnt); else passed++;
        cyc();
        rst_n = 1'b0;
        set_req(3'b111, 7'h00, 7'h01, 7'h02);
        #1;
        checks++; if (bus_rr.cpu_gnt !== 3'b000) $display("FAIL rst_low_gnt got %b want 000", bus_rr.cpu_gnt); else passed++;
        checks++; if (bus_rr.bank_re !== 3'b000) $display("FAIL rst_low_bank_re got %b want 000", bus_rr.bank_re); else passed++;
        cyc();
        rst_n = 1'b1;
        set_req(3'b000, 7'h00, 7'h00, 7'h00);
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (bus_rr.cpu_rsp_vld !== 3'b000) $display("FAIL rst_drop_vld k=%0d got %b want 000", k, bus_rr.cpu_rsp_vld); else passed++;
            cyc();
        end
        set_req(3'b111, 7'h20, 7'h21, 7'h22);
        #1;
        checks++; if (bus_rr.cpu_gnt !== 3'b001) $display("FAIL rst_first_gnt got %b want 001", bus_rr.cpu_gnt); else passed++;
        cyc(); #1;
        checks++; if (bus_rr.cpu_gnt !== 3'b010) $display("FAIL rst_second_gnt got %b want 010", bus_rr.cpu_gnt); else passed++;
        set_req(3'b000, 7'h00, 7'h00, 7'h00);
    endtask

    initial begin
        set_req(3'b000, 7'h00, 7'h00, 7'h00);
        bus_fx.cpu_req  = 3'b000;
        bus_fx.cpu_addr = '0;
        test_reset();
        test_single();
        test_rr_conflict();
        test_parallel_banks();
        test_out_of_range();
        test_fixed_priority();
        test_reset_inflight();
        cyc(); cyc();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
